integer_issue_sched: RTL and testbench
======================================

# integer_issue_sched

Issue scheduler between the integer issue queue (IIQ) and the integer execute stage. Each cycle it selects one ready IIQ entry (oldest by ROB age, or lowest index), grants it for dequeue, and latches its index and ROB id into a single issue pipeline register that feeds integer execute. It applies backpressure from execute and squashes younger work on a branch/jalr misprediction flush.

## Interface
- `N_ENTRIES`, default 8: number of IIQ entries; power of two, ≥ 2.
- `ROB_ID_WIDTH`, default 5: width of a ROB id.
- `clk`  in  1: clock.
- `rst_aL`  in  1: reset; synchronous, active-low. One clock; all state updates on the rising edge of `clk`.
- `entry_ready`  in  N_ENTRIES: entry i is valid and both sources are available.
- `entry_rob_id`  in  N_ENTRIES*ROB_ID_WIDTH: ROB id of entry i, packed in slice [i*ROB_ID_WIDTH +: ROB_ID_WIDTH].
- `rob_head_id`  in  ROB_ID_WIDTH: ROB id of the oldest in-flight instruction.
- `ex_ready`  in  1: execute accepts the issue register contents this cycle.
- `flush`  in  1: misprediction flush this cycle.
- `flush_rob_id`  in  ROB_ID_WIDTH: ROB id of the mispredicting instruction. That instruction survives; only younger ones are killed.
- `grant`  out  N_ENTRIES: one-hot or zero. Combinational. The IIQ dequeues the granted entry at the coming edge.
- `issue_valid`  out  1: issue register holds a live instruction.
- `issue_idx`  out  $clog2(N_ENTRIES): IIQ index held in the issue register.
- `issue_rob_id`  out  ROB_ID_WIDTH: ROB id held in the issue register.

## Operation
- Age of ROB id x is (x − `rob_head_id`) mod 2^ROB_ID_WIDTH. A smaller age is older. The subtraction wraps in ROB_ID_WIDTH bits.
- `can_load` = !`issue_valid` | `ex_ready`.
- Selection:
  - Candidate set is `entry_ready`.
  - The winner is the candidate with minimum age.
  - Ties (duplicate ROB ids, which are illegal) are broken toward the lowest index.
- `grant` is the one-hot winner only when all of the following hold:
  - `can_load`
  - !`flush`
  - at least one candidate exists
  
  Otherwise `grant` is 0.
- Issue register next state, in priority order:
  1. Reset (`rst_aL`=0): `issue_valid`=0, `issue_idx`=0, `issue_rob_id`=0.
  2. `flush`: if `issue_valid` and age(`issue_rob_id`) > age(`flush_rob_id`), clear `issue_valid`. Otherwise hold. No load this cycle.
  3. `grant` nonzero: load the winner's index and ROB id, and set `issue_valid`=1.
  4. `issue_valid` & `ex_ready` with no grant: clear `issue_valid`.
  5. Otherwise: hold.
- Execute consumes the register contents on any edge where `issue_valid` & `ex_ready`.
- The register is never overwritten while `issue_valid` & !`ex_ready`. Contents stay stable under stall.

## Timing
- Ready-to-grant latency is 0 cycles (same cycle). Grant-to-`issue_valid` latency is 1 cycle.
- Throughput is 1 issue per cycle when `ex_ready` is held high.
- Full stall: with `issue_valid`=1 and `ex_ready`=0, `grant`=0 and the outputs hold.
- Empty: with no candidates, `grant`=0. `issue_valid` drops after the held instruction is consumed.
- Flush and `ex_ready` in the same cycle: flush wins. There is no load; the register is either killed or held.
- A surviving held instruction (older than or equal to `flush_rob_id`) remains valid.
- ROB id wrap-around: ages are computed relative to `rob_head_id`. An id numerically below the head is younger than an id numerically above it.
- Reset mid-stall: the register clears at the reset edge and `grant`=0 while `rst_aL`=0.
- `grant` depends only on current inputs and `issue_valid`. There is no combinational path from `grant` back to itself.

## Configuration
- `IIQ_AGE_SELECT_EN`:
  - Defined: oldest-first selection as above.
  - Undefined: fixed priority, where the lowest-index ready entry wins. The age comparators for selection are not built.
  - Flush kill logic is identical in both builds.

## Test plan
- Oldest-first with wrap: `N_ENTRIES`=8, `ROB_ID_WIDTH`=5, `rob_head_id`=30.
  - Stimulus: entries 2/5/6 ready with ROB ids 3/31/1; `ex_ready`=1.
  - Required response: `grant`=8'b0010_0000, then ids issue in order 31, 1, 3 on consecutive cycles (entries dropped after grant).
  - With the macro off: `grant`=8'b0000_0100 first.
- Stall:
  - Stimulus: `issue_valid`=1 with `issue_rob_id`=4, `ex_ready`=0 for 3 cycles, entries ready.
  - Required response: `grant`=0 and outputs unchanged for 3 cycles.
  - On `ex_ready`=1 the next winner is granted that cycle and loaded next edge.
- Flush younger:
  - Stimulus: `rob_head_id`=0, `issue_rob_id`=7 valid, `flush`=1, `flush_rob_id`=5.
  - Required response: `issue_valid`=0 next cycle, `grant`=0 during the flush.
- Flush older:
  - Stimulus: same as flush younger but `flush_rob_id`=9.
  - Required response: the register holds id 7, valid.
- Reset:
  - Stimulus: assert `rst_aL`=0 mid-stream for 1 cycle.
  - Required response: `issue_valid`=0, `issue_idx`=0, `issue_rob_id`=0.
  - After `rst_aL` returns high, the first grant occurs in the next cycle with ready entries.
- Back-to-back:
  - Stimulus: all 8 ready with ids 0..7, `rob_head_id`=0, `ex_ready`=1, grants retire entries.
  - Required response: 8 issues in 8 cycles, ids 0..7 in order.

Source files
------------

// File: rtl/integer_issue_sched_if.sv
// Interface between the integer issue scheduler, the integer issue queue and
// the integer execute stage. The scheduler connects through the slave modport.
// The IIQ/execute side connects through the master modport.
interface integer_issue_sched_if #(
  parameter int N_ENTRIES    = 8,
  parameter int ROB_ID_WIDTH = 5
);
  localparam int IDX_W = $clog2(N_ENTRIES);

  logic [N_ENTRIES-1:0]              entry_ready;
  logic [N_ENTRIES*ROB_ID_WIDTH-1:0] entry_rob_id;
  logic [ROB_ID_WIDTH-1:0]           rob_head_id;
  logic                              ex_ready;
  logic                              flush;
  logic [ROB_ID_WIDTH-1:0]           flush_rob_id;
  logic [N_ENTRIES-1:0]              grant;
  logic                              issue_valid;
  logic [IDX_W-1:0]                  issue_idx;
  logic [ROB_ID_WIDTH-1:0]           issue_rob_id;

  modport master (
    output entry_ready, entry_rob_id, rob_head_id, ex_ready, flush, flush_rob_id,
    input  grant, issue_valid, issue_idx, issue_rob_id
  );

  modport slave (
    input  entry_ready, entry_rob_id, rob_head_id, ex_ready, flush, flush_rob_id,
    output grant, issue_valid, issue_idx, issue_rob_id
  );
endinterface

// File: rtl/integer_issue_sched.sv
// Integer issue scheduler: picks one ready IIQ entry per cycle, grants it for
// dequeue and latches its index and ROB id into the issue register that feeds
// integer execute. Honours execute backpressure and kills younger work on a
// misprediction flush.
// Build option IIQ_AGE_SELECT_EN: when defined, the oldest ready entry (by ROB
// age relative to rob_head_id) wins; when undefined, the lowest-index ready
// entry wins and no selection age comparators are built.
module integer_issue_sched #(
  parameter int N_ENTRIES    = 8,
  parameter int ROB_ID_WIDTH = 5
) (
  input logic                 clk,
  input logic                 rst_aL,
  integer_issue_sched_if.slave bus
);
  localparam int IDX_W = $clog2(N_ENTRIES);

  logic                    issue_valid_q;
  logic [IDX_W-1:0]        issue_idx_q;
  logic [ROB_ID_WIDTH-1:0] issue_rob_id_q;

  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [ROB_ID_WIDTH-1:0] win_rob_id;
  logic                    can_load;
  logic                    do_grant;
  logic [ROB_ID_WIDTH-1:0] issue_age;
  logic [ROB_ID_WIDTH-1:0] flush_age;
  logic                    flush_kill;

`ifdef IIQ_AGE_SELECT_EN
  logic [ROB_ID_WIDTH-1:0] cand_age;
  logic [ROB_ID_WIDTH-1:0] win_age;

  // Oldest-first select: strict less-than keeps the lowest index on ties.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is
    // inferred; blocking '=' is correct here because later iterations must
    // see the running winner written by earlier ones.
    win_found  = 1'b0;
    win_idx    = '0;
    win_rob_id = '0;
    win_age    = '0;
    cand_age   = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      cand_age = bus.entry_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH] - bus.rob_head_id;
      if (bus.entry_ready[i] && (!win_found || cand_age < win_age)) begin
        win_found  = 1'b1;
        win_idx    = IDX_W'(i);
        win_rob_id = bus.entry_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
        win_age    = cand_age;
      end
    end
  end
`else
  // Fixed-priority select: the lowest-index ready entry wins.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_rob_id = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (bus.entry_ready[i] && !win_found) begin
        win_found  = 1'b1;
        win_idx    = IDX_W'(i);
        win_rob_id = bus.entry_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
      end
    end
  end
`endif

  // The register may load when empty or when execute drains it this edge.
  // Grant is suppressed during flush and while reset is asserted.
  assign can_load = !issue_valid_q || bus.ex_ready;
  assign do_grant = rst_aL && can_load && !bus.flush && win_found;

  // Flush kills the held instruction only if it is strictly younger than the
  // mispredicting one; ages wrap in ROB_ID_WIDTH bits.
  assign issue_age  = issue_rob_id_q - bus.rob_head_id;
  assign flush_age  = bus.flush_rob_id - bus.rob_head_id;
  assign flush_kill = issue_valid_q && (issue_age > flush_age);

  // One-hot grant of the winner, zero when no load is allowed.
  always_comb begin
    bus.grant = '0;
    if (do_grant) bus.grant[win_idx] = 1'b1;
  end

  // Issue register: reset, then flush, then load, then drain, else hold.
  always_ff @(posedge clk) begin
    // NOTE: the payload fields are cleared on reset too, so issue_idx and
    // issue_rob_id read as zero after reset rather than as stale values.
    if (!rst_aL) begin
      issue_valid_q  <= 1'b0;
      issue_idx_q    <= '0;
      issue_rob_id_q <= '0;
    end else if (bus.flush) begin
      if (flush_kill) issue_valid_q <= 1'b0;
    end else if (do_grant) begin
      issue_valid_q  <= 1'b1;
      issue_idx_q    <= win_idx;
      issue_rob_id_q <= win_rob_id;
    end else if (issue_valid_q && bus.ex_ready) begin
      issue_valid_q <= 1'b0;
    end
  end

  assign bus.issue_valid  = issue_valid_q;
  assign bus.issue_idx    = issue_idx_q;
  assign bus.issue_rob_id = issue_rob_id_q;
endmodule

// File: tb/tb_integer_issue_sched.sv
// Self-checking bench for integer_issue_sched: table-driven grant vectors,
// hand-written multi-cycle sequences and randomized traffic against a
// behavioural model. Honours IIQ_AGE_SELECT_EN the same way as the design.
module tb_integer_issue_sched;
  localparam int N  = 8;
  localparam int W  = 5;
  localparam int IW = 3;
  localparam int ROB_SIZE = 1 << W;

  logic clk = 1'b0;
  logic rst_aL;
  always #5 clk = ~clk;

  integer_issue_sched_if #(.N_ENTRIES(N), .ROB_ID_WIDTH(W)) bus ();
  integer_issue_sched #(.N_ENTRIES(N), .ROB_ID_WIDTH(W)) dut (
    .clk(clk), .rst_aL(rst_aL), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Bench-side stimulus state.
  logic [N-1:0] ready;
  int           ids[N];
  int           head;
  bit           ex_ready;
  bit           flush;
  int           flush_id;

  // Behavioural model of the issue register.
  bit           m_valid;
  int           m_idx;
  int           m_rob;
  logic [N-1:0] m_grant;

  typedef struct {
    logic [N-1:0] ready;
    int           ids[N];
    int           head;
    bit           flush;
    logic [N-1:0] exp_grant;
    int           exp_rob;
  } vec_t;

  vec_t vecs[7];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int age(int x, int h);
    return (x - h + ROB_SIZE) % ROB_SIZE;
  endfunction

  function automatic int winner();
    int best = -1;
    for (int i = 0; i < N; i++) begin
      if (ready[i]) begin
`ifdef IIQ_AGE_SELECT_EN
        if (best < 0 || age(ids[i], head) < age(ids[best], head)) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  task automatic drive();
    bus.entry_ready  = ready;
    for (int i = 0; i < N; i++) bus.entry_rob_id[i*W +: W] = W'(ids[i]);
    bus.rob_head_id  = W'(head);
    bus.ex_ready     = ex_ready;
    bus.flush        = flush;
    bus.flush_rob_id = W'(flush_id);
  endtask

  // One clock: check grant before the edge, advance model, check register after.
  task automatic step(string tag);
    int w;
    logic [N-1:0] g;
    drive();
    #1;
    w = winner();
    g = '0;
    if (rst_aL && (!m_valid || ex_ready) && !flush && w >= 0) g[w] = 1'b1;
    m_grant = g;
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    @(posedge clk);
    if (!rst_aL) begin
      m_valid = 0; m_idx = 0; m_rob = 0;
    end else if (flush) begin
      if (m_valid && age(m_rob, head) > age(flush_id, head)) m_valid = 0;
    end else if (g != '0) begin
      m_valid = 1; m_idx = w; m_rob = ids[w];
    end else if (m_valid && ex_ready) begin
      m_valid = 0;
    end
    #1;
    check({tag, ".valid"}, 32'(bus.issue_valid), 32'(m_valid));
    check({tag, ".idx"}, 32'(bus.issue_idx), 32'(m_idx));
    check({tag, ".rob"}, 32'(bus.issue_rob_id), 32'(m_rob));
  endtask

  task automatic clear_inputs();
    ready = '0;
    for (int i = 0; i < N; i++) ids[i] = 0;
    head = 0; ex_ready = 1'b0; flush = 1'b0; flush_id = 0;
  endtask

  task automatic drain();
    ready = '0; flush = 1'b0; ex_ready = 1'b1;
    step("drain");
  endtask

  task automatic load_one(int e, int id);
    clear_inputs();
    ready[e] = 1'b1; ids[e] = id;
    step("load");
    check("load_valid", 32'(bus.issue_valid), 32'd1);
    check("load_rob", 32'(bus.issue_rob_id), 32'(id));
  endtask

  initial begin
    int exp_order[3];
    int tmp;
    int j;
    clear_inputs();
    rst_aL = 1'b0;
    m_valid = 0; m_idx = 0; m_rob = 0; m_grant = '0;
    drive();
    @(posedge clk); @(posedge clk); #1;

    // Reset state.
    check("rst_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_idx", 32'(bus.issue_idx), 32'd0);
    check("rst_rob", 32'(bus.issue_rob_id), 32'd0);
    ready = 8'hFF;
    step("rst_hold");
    rst_aL = 1'b1;
    clear_inputs();

    // ---------------- table-driven grant vectors ----------------
    foreach (vecs[k]) begin
      vecs[k].ready = '0; vecs[k].head = 0; vecs[k].flush = 0;
      vecs[k].exp_grant = '0; vecs[k].exp_rob = 0;
      for (int i = 0; i < N; i++) vecs[k].ids[i] = 0;
    end
    // wrap: head 30, ids 3/31/1 at entries 2/5/6
    vecs[0].ready = 8'b0110_0100; vecs[0].head = 30;
    vecs[0].ids[2] = 3; vecs[0].ids[5] = 31; vecs[0].ids[6] = 1;
`ifdef IIQ_AGE_SELECT_EN
    vecs[0].exp_grant = 8'b0010_0000; vecs[0].exp_rob = 31;
`else
    vecs[0].exp_grant = 8'b0000_0100; vecs[0].exp_rob = 3;
`endif
    // empty
    vecs[1].ready = '0;
    // all ready ids 0..7
    vecs[2].ready = 8'hFF;
    for (int i = 0; i < N; i++) vecs[2].ids[i] = i;
    vecs[2].exp_grant = 8'h01; vecs[2].exp_rob = 0;
    // highest index oldest
    vecs[3].ready = 8'b1000_0001; vecs[3].head = 8;
    vecs[3].ids[0] = 10; vecs[3].ids[7] = 9;
`ifdef IIQ_AGE_SELECT_EN
    vecs[3].exp_grant = 8'h80; vecs[3].exp_rob = 9;
`else
    vecs[3].exp_grant = 8'h01; vecs[3].exp_rob = 10;
`endif
    // duplicate ids: lowest index wins
    vecs[4].ready = 8'b0001_1000; vecs[4].ids[3] = 12; vecs[4].ids[4] = 12;
    vecs[4].exp_grant = 8'h08; vecs[4].exp_rob = 12;
    // flush blocks grant
    vecs[5].ready = 8'hFF; vecs[5].flush = 1'b1;
    // head 31: id 31 is older than id 0
    vecs[6].ready = 8'b0000_0011; vecs[6].head = 31;
    vecs[6].ids[0] = 0; vecs[6].ids[1] = 31;
`ifdef IIQ_AGE_SELECT_EN
    vecs[6].exp_grant = 8'h02; vecs[6].exp_rob = 31;
`else
    vecs[6].exp_grant = 8'h01; vecs[6].exp_rob = 0;
`endif

    for (int k = 0; k < 7; k++) begin
      clear_inputs();
      ready = vecs[k].ready; head = vecs[k].head; flush = vecs[k].flush;
      flush_id = 0; ex_ready = 1'b1;
      for (int i = 0; i < N; i++) ids[i] = vecs[k].ids[i];
      drive();
      #1;
      check($sformatf("tbl%0d.grant", k), 32'(bus.grant), 32'(vecs[k].exp_grant));
      step($sformatf("tbl%0d", k));
      check($sformatf("tbl%0d.valid", k), 32'(bus.issue_valid),
            32'(vecs[k].exp_grant != '0));
      if (vecs[k].exp_grant != '0)
        check($sformatf("tbl%0d.rob", k), 32'(bus.issue_rob_id), 32'(vecs[k].exp_rob));
      drain();
    end

    // ---------------- oldest-first issue order with wrap ----------------
    clear_inputs();
    ready = 8'b0110_0100; head = 30; ex_ready = 1'b1;
    ids[2] = 3; ids[5] = 31; ids[6] = 1;
`ifdef IIQ_AGE_SELECT_EN
    exp_order = '{31, 1, 3};
`else
    exp_order = '{3, 31, 1};
`endif
    for (int k = 0; k < 3; k++) begin
      step("order");
      check($sformatf("order%0d.valid", k), 32'(bus.issue_valid), 32'd1);
      check($sformatf("order%0d.rob", k), 32'(bus.issue_rob_id), 32'(exp_order[k]));
      ready = ready & ~m_grant;
    end
    drain();
    check("empty_valid", 32'(bus.issue_valid), 32'd0);

    // ---------------- stall ----------------
    load_one(0, 4);
    ready = 8'b0000_0110; ids[1] = 6; ids[2] = 5; ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(); #1;
      check("stall.grant", 32'(bus.grant), 32'd0);
      step("stall");
      check("stall.valid", 32'(bus.issue_valid), 32'd1);
      check("stall.idx", 32'(bus.issue_idx), 32'd0);
      check("stall.rob", 32'(bus.issue_rob_id), 32'd4);
    end
    ex_ready = 1'b1;
    drive(); #1;
`ifdef IIQ_AGE_SELECT_EN
    check("unstall.grant", 32'(bus.grant), 32'h04);
    step("unstall");
    check("unstall.rob", 32'(bus.issue_rob_id), 32'd5);
`else
    check("unstall.grant", 32'(bus.grant), 32'h02);
    step("unstall");
    check("unstall.rob", 32'(bus.issue_rob_id), 32'd6);
`endif
    drain();

    // ---------------- flush younger ----------------
    load_one(3, 7);
    ready = 8'b0001_0000; ids[4] = 2; ex_ready = 1'b0;
    flush = 1'b1; flush_id = 5;
    drive(); #1;
    check("flush_y.grant", 32'(bus.grant), 32'd0);
    step("flush_y");
    check("flush_y.valid", 32'(bus.issue_valid), 32'd0);
    drain();

    // ---------------- flush older, with ex_ready high (flush wins) ----------------
    load_one(3, 7);
    ready = 8'b0001_0000; ids[4] = 2; ex_ready = 1'b1;
    flush = 1'b1; flush_id = 9;
    step("flush_o");
    check("flush_o.valid", 32'(bus.issue_valid), 32'd1);
    check("flush_o.rob", 32'(bus.issue_rob_id), 32'd7);
    // flush on the held instruction itself: it survives
    flush_id = 7;
    step("flush_eq");
    check("flush_eq.valid", 32'(bus.issue_valid), 32'd1);
    drain();

    // ---------------- reset mid-stream ----------------
    load_one(3, 7);
    ready = 8'b0001_0000; ids[4] = 2; ex_ready = 1'b0;
    rst_aL = 1'b0;
    drive(); #1;
    check("rst_mid.grant", 32'(bus.grant), 32'd0);
    step("rst_mid");
    check("rst_mid.valid", 32'(bus.issue_valid), 32'd0);
    check("rst_mid.idx", 32'(bus.issue_idx), 32'd0);
    check("rst_mid.rob", 32'(bus.issue_rob_id), 32'd0);
    rst_aL = 1'b1; ex_ready = 1'b1;
    step("rst_after");
    check("rst_after.valid", 32'(bus.issue_valid), 32'd1);
    check("rst_after.rob", 32'(bus.issue_rob_id), 32'd2);
    drain();

    // ---------------- back-to-back ----------------
    clear_inputs();
    ready = 8'hFF; ex_ready = 1'b1;
    for (int i = 0; i < N; i++) ids[i] = i;
    for (int k = 0; k < N; k++) begin
      step("b2b");
      check($sformatf("b2b%0d.valid", k), 32'(bus.issue_valid), 32'd1);
      check($sformatf("b2b%0d.rob", k), 32'(bus.issue_rob_id), 32'(k));
      ready = ready & ~m_grant;
    end
    drain();
    check("b2b_end.valid", 32'(bus.issue_valid), 32'd0);

    // ---------------- randomized traffic against the model ----------------
    for (int c = 0; c < 400; c++) begin
      tmp = int'($urandom_range(0, ROB_SIZE - 1));
      for (int i = 0; i < N; i++) ids[i] = (tmp + i) % ROB_SIZE;
      for (int i = N - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = ids[i]; ids[i] = ids[j]; ids[j] = tmp;
      end
      ready    = N'($urandom);
      head     = int'($urandom_range(0, ROB_SIZE - 1));
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 7) == 0);
      flush_id = int'($urandom_range(0, ROB_SIZE - 1));
      rst_aL   = ($urandom_range(0, 99) != 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
